// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state codes, column reset value and key-encoding helpers
package keypad_pkg;
    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] REPORT   = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;
    localparam logic [3:0] COL_RESET = 4'b0001;
    function automatic logic [3:0] encode_key(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction
    function automatic logic [1:0] lowest_bit(input logic [3:0] v);
        return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: counts consecutive cycles of level == polarity; done on the last one
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic polarity,
    input  logic start,
    output logic done
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);
    logic [CW-1:0] cnt;
    logic match;
    assign match = level == polarity;
    assign done = match && cnt == LAST;
    // saturates at the terminal count; any mismatch restarts the run
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else
            cnt <= (start || !match) ? '0 : (cnt == LAST) ? cnt : cnt + 1'b1;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with press/release debounce
// and a valid/ack handshake for the encoded key code
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] code,
    output logic       valid,
    input  logic       ack
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    logic [3:0] row_m, row_s;
    logic [1:0] state;
    logic [DW-1:0] dwell;
    logic [1:0] r_idx, c_idx;
    logic db_done;
    keypad_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .level    (row_s[r_idx]),
        .polarity (state == DEBOUNCE),
        .start    (!(state == DEBOUNCE || state == RELEASE)),
        .done     (db_done)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_m <= '0;
            row_s <= '0;
            state <= SCAN;
            col   <= COL_RESET;
            code  <= '0;
            valid <= 1'b0;
            dwell <= '0;
            r_idx <= '0;
            c_idx <= '0;
        end else begin
            row_m <= row;
            row_s <= row_m;
            case (state)
                SCAN:
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (|row_s) begin
                            r_idx <= lowest_bit(row_s);
                            c_idx <= lowest_bit(col);
                            state <= DEBOUNCE;
                        end else
                            col <= {col[2:0], col[3]};
                    end else
                        dwell <= dwell + 1'b1;
                DEBOUNCE:
                    if (!row_s[r_idx]) begin
                        state <= SCAN;
                        col   <= {col[2:0], col[3]};
                    end else if (db_done) begin
                        code  <= encode_key(r_idx, c_idx);
                        valid <= 1'b1;
                        state <= REPORT;
                    end
                REPORT:
                    if (ack) begin
                        valid <= 1'b0;
                        state <= RELEASE;
                    end
                default:
                    if (db_done) begin
                        state <= SCAN;
                        col   <= {col[2:0], col[3]};
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed closed-loop keypad scenarios with hand-timed expectations
module tb_keypad_scan_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ack = 1'b0;
    logic [3:0] row, col, code;
    logic valid;
    logic [15:0] key = '0;
    int n_checks = 0;
    int n_fail = 0;
    int xfers, ok, n;

    always #5 clk = ~clk;

    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++) row[r] = |(key[4*r +: 4] & col);
    end

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .row   (row),
        .col   (col),
        .code  (code),
        .valid (valid),
        .ack   (ack)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        wait_n(2);
        check("rst_col", col, 4'b0001);
        check("rst_valid", valid, 0);
        check("rst_code", code, 0);
        reset = 1'b0;
        // idle sweep
        wait_n(3); check("idle_c0", col, 4'b0001);
        wait_n(1); check("idle_c1", col, 4'b0010);
        wait_n(4); check("idle_c2", col, 4'b0100);
        wait_n(4); check("idle_c3", col, 4'b1000);
        wait_n(4); check("idle_wrap", col, 4'b0001);
        check("idle_valid", valid, 0);
        // key 9: row 2, column 1
        key[9] = 1'b1;
        wait_n(10); check("k9_pre", valid, 0);
        wait_n(1);
        check("k9_valid", valid, 1);
        check("k9_code", code, 4'h9);
        check("k9_col", col, 4'b0010);
        wait_n(2); check("k9_hold", valid, 1);
        ack = 1'b1;
        wait_n(1); check("k9_ack", valid, 0);
        ack = 1'b0;
        key = '0;
        wait_n(4); check("k9_rel_hold", col, 4'b0010);
        wait_n(1); check("k9_resume", col, 4'b0100);
        wait_n(4); check("k9_next", col, 4'b1000);
        // key 6 bounce, then stable
        wait_n(12); key[6] = 1'b1;
        wait_n(2);  key[6] = 1'b0; check("k6_b0", valid, 0);
        wait_n(1);  key[6] = 1'b1;
        wait_n(2);
        check("k6_abort_col", col, 4'b1000);
        check("k6_abort_valid", valid, 0);
        wait_n(18); check("k6_pre", valid, 0);
        wait_n(1);
        check("k6_valid", valid, 1);
        check("k6_code", code, 4'h6);
        ack = 1'b1;
        wait_n(1); check("k6_ack", valid, 0);
        key = '0;
        wait_n(4);
        check("k6_ackheld", valid, 0);
        check("k6_rel_hold", col, 4'b0100);
        ack = 1'b0;
        wait_n(1); check("k6_resume", col, 4'b1000);
        // keys 4 and 12 share column 0: lowest row wins
        key[4] = 1'b1; key[12] = 1'b1;
        wait_n(10); check("k4_pre", valid, 0);
        wait_n(1);
        check("k4_valid", valid, 1);
        check("k4_code", code, 4'h4);
        check("k4_col", col, 4'b0001);
        ack = 1'b1;
        wait_n(1); check("k4_ack", valid, 0);
        ack = 1'b0;
        wait_n(10);
        check("k4_no_second", valid, 0);
        check("k4_rel_col", col, 4'b0001);
        key = '0;
        wait_n(4); check("k4_rel_hold", col, 4'b0001);
        wait_n(1); check("k4_resume", col, 4'b0010);
        // key 15 with a slow consumer
        key[15] = 1'b1;
        wait_n(14); check("kf_pre", valid, 0);
        wait_n(1);
        check("kf_valid", valid, 1);
        check("kf_code", code, 4'hf);
        ok = 1;
        repeat (50) begin
            wait_n(1);
            if (!(valid === 1'b1 && code === 4'hf)) ok = 0;
        end
        check("kf_stable", ok[0], 1);
        ack = 1'b1;
        xfers = 0;
        repeat (5) begin
            if (valid) xfers++;
            wait_n(1);
        end
        ack = 1'b0;
        check("kf_xfers", xfers[3:0], 1);
        check("kf_valid_off", valid, 0);
        key = '0;
        wait_n(10); check("kf_idle", valid, 0);
        // reset during REPORT
        key[5] = 1'b1;
        n = 0;
        while (!valid && n < 40) begin
            wait_n(1);
            n++;
        end
        check("k5_valid", valid, 1);
        check("k5_code", code, 4'h5);
        reset = 1'b1;
        #1;
        check("arst_valid", valid, 0);
        check("arst_code", code, 0);
        check("arst_col", col, 4'b0001);
        key = '0;
        @(negedge clk) reset = 1'b0;
        wait_n(3); check("post_c0", col, 4'b0001);
        wait_n(1); check("post_c1", col, 4'b0010);
        check("post_valid", valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencing controller for the 4x4 hex keypad. Drives the column lines one-hot and samples the row lines. When a key is found it debounces the press and encodes it to a 4-bit hex code. It then presents the code on a valid/ack handshake and waits for a debounced release before scanning resumes. The block sits between the keypad (modelled by `Row_signal`: key index 4*r+c, asserted on row r while col c is driven) and downstream code consumers.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven per scan step; legal range >= 2.
- DEBOUNCE_CNT, 20000: consecutive stable cycles required for a press and for a release; legal range >= 1.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- row  in  4  row sense lines, active-high; arrive asynchronously and are synchronised internally.
- col  out  4  column drive, one-hot, active-high; registered.
- code  out  4  hex code {row_idx[1:0], col_idx[1:0]} = 4*r+c; registered; stable while valid.
- valid  out  1  code available; held until accepted.
- ack  in  1  consumer accept; the transfer occurs on a cycle with valid && ack.

## Operation
- Synchroniser: row passes through 2 flops (row_s). All decisions use row_s.
- Reset values: col=4'b0001, code=4'h0, valid=0, state=SCAN, all counters 0.
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1 while col is held.
  - row_s is sampled at dwell == SCAN_DIV-1.
  - If row_s == 0: col rotates 0001->0010->0100->1000->0001 and dwell restarts.
  - If row_s != 0: capture r = index of the lowest set bit (lowest row wins), capture c = current column, keep col, go to DEBOUNCE with the debounce counter at 0.
- DEBOUNCE:
  - Each cycle with row_s[r]=1, the counter increments.
  - Any cycle with row_s[r]=0 aborts back to SCAN. col advances to the next column and dwell restarts at 0; no code is reported.
  - When the counter == DEBOUNCE_CNT-1 and row_s[r]=1: load code={r,c}, set valid=1, go to REPORT.
- REPORT:
  - valid and code are held; col is held.
  - On valid && ack: clear valid and go to RELEASE with the counter at 0.
  - A key release while in REPORT does not retract valid.
- RELEASE:
  - Counter increments on cycles with row_s[r]=0; it resets to 0 on any cycle with row_s[r]=1.
  - At counter == DEBOUNCE_CNT-1 with row_s[r]=0: go to SCAN, advance col to the next column, dwell restarts.
- ack outside REPORT is ignored.
- A second key pressed in another row or column during DEBOUNCE, REPORT or RELEASE is ignored; only row r of column c is monitored.
- Reset asserted in any state (including mid-handshake): immediate return to reset values. A pending code is discarded.

## Timing
- All outputs are registered; there is no combinational path from ack or row to any output.
- Synchroniser latency: 2 cycles.
- Scan step: col changes exactly every SCAN_DIV cycles in SCAN. A full sweep takes 4*SCAN_DIV cycles.
- Press latency:
  - From entering DEBOUNCE, valid rises at the DEBOUNCE_CNT-th subsequent edge.
  - Worst case from a stable press at the row pins: 2 + 4*SCAN_DIV + DEBOUNCE_CNT cycles.
- Handshake:
  - valid falls on the edge after the valid && ack cycle.
  - ack held high continuously accepts exactly one code per press.
- Release: SCAN resumes DEBOUNCE_CNT cycles after row_s[r] is first continuously low in RELEASE.
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_CNT+1). No wrap occurs; counters saturate at terminal count and restart on state entry.

## Structure
- keypad_pkg holds:
  - the state enum {SCAN, DEBOUNCE, REPORT, RELEASE};
  - the column reset constant 4'b0001;
  - a function encoding (row_idx, col_idx) to a 4-bit code;
  - a function returning the lowest-set-bit index of a 4-bit vector.
- One sub-module is natural: `keypad_debounce`, a stable-level counter (inputs: level, target polarity, start; output: done). It is reused for both the press and release phases.
- The synchroniser and FSM live in keypad_scan_ctrl.

## Test plan
Bench uses SCAN_DIV=4 and DEBOUNCE_CNT=3 and closes the loop through `Row_signal` (key vector driven by the test).
- Reset, no keys -> col=0001 and cycles 0010, 0100, 1000, 0001 every 4 cycles; valid=0, code=0.
- key[9] held; ack pulsed 2 cycles after valid -> valid=1 with code=4'h9; after release and 3 low cycles, scanning resumes from the column after col[1].
- key[6] bounces (high 2 cycles, low 1) then stable -> first attempt aborts with no valid; eventually a single valid with code=4'h6.
- key[4] and key[12] held together (same column 0) -> code=4'h4, lowest row wins; after ack with both still held, no second valid until both are released.
- Key held, ack held low for 50 cycles -> valid and code stay constant; ack high for 5 cycles yields one transfer only.
- Reset asserted while in REPORT -> valid=0, code=0, col=0001 immediately (asynchronously); normal scan after deassertion.
